// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - load/store request and response channels between execute stage and data memory
interface data_mem_responder_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data memory responder with programmable wait states
module data_mem_responder #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   data_mem_responder_if.slave  bus
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_C   = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0]      WAIT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                write_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic                latch, access;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                acc_write;
   logic [ADDR_W-1:0]   acc_addr;
   logic [DATA_W-1:0]   acc_wdata;
   logic                in_range;
   logic [IDX_W-1:0]    idx;

   // With zero wait states the RAM access shares the acceptance edge, so it uses the live request fields.
   assign acc_write = (state_q == S_IDLE) ? bus.req_write : write_q;
   assign acc_addr  = (state_q == S_IDLE) ? bus.req_addr  : addr_q;
   assign acc_wdata = (state_q == S_IDLE) ? bus.req_wdata : wdata_q;
   assign in_range  = ({1'b0, acc_addr} < DEPTH_C);
   assign idx       = acc_addr[IDX_W-1:0];

   assign bus.req_ready = (state_q == S_IDLE) && rst_n;
   assign bus.rsp_valid = (state_q == S_RESP);
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      latch   = 1'b0;
      access  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid && bus.req_ready) begin
               latch = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_d = S_RESP;
                  access  = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
               access  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               state_d = S_IDLE;
               err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (access) begin
         err_d   = !in_range;
         rdata_d = (acc_write || !in_range) ? '0 : mem_q[idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         if (latch) begin
            write_q <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end
      end
   end

   // Storage is not reset; an access aborted by reset never reaches this edge because state_q is already IDLE.
   always_ff @(posedge clk) begin
      if (access && acc_write && in_range) begin
         mem_q[idx] <= acc_wdata;
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder against a memory model
module tb_data_mem_responder;
   localparam int WAITC = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_mem_responder_if #(.ADDR_W(16), .DATA_W(32)) b0 ();
   data_mem_responder_if #(.ADDR_W(16), .DATA_W(32)) b1 ();

   data_mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(WAITC)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .bus(b0.slave)
   );
   data_mem_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(b1.slave)
   );

   int errors = 0;
   int checks = 0;
   logic [31:0] ref_mem [int];
   int cyc = 0;
   int acc_q[$];
   logic mon_en = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mon_en && b0.req_valid && b0.req_ready) acc_q.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic txn0(input logic wr, input logic [15:0] a, input logic [31:0] wd, input int hold);
      int n;
      logic exp_err;
      logic known;
      logic [31:0] exp_rd;
      exp_err = (a >= 16'd1024);
      known   = wr || exp_err || ref_mem.exists(int'(a));
      exp_rd  = (wr || exp_err || !known) ? 32'h0 : ref_mem[int'(a)];
      @(negedge clk);
      b0.req_valid = 1'b1; b0.req_write = wr; b0.req_addr = a; b0.req_wdata = wd; b0.rsp_ready = 1'b0;
      n = 0;
      while (!b0.req_ready && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk("accept_timeout", 32'd0, 32'd1);
      @(negedge clk);
      b0.req_valid = 1'b0; b0.req_write = ~wr; b0.req_addr = 16'($urandom); b0.req_wdata = $urandom;
      n = 1;
      while (!b0.rsp_valid && n < 40) begin @(negedge clk); n++; end
      chk("latency", n, WAITC + 1);
      chk("rsp_err", b0.rsp_err, exp_err);
      if (known) chk("rsp_rdata", b0.rsp_rdata, exp_rd);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", b0.rsp_valid, 1);
         chk("hold_err", b0.rsp_err, exp_err);
         chk("hold_req_ready", b0.req_ready, 0);
         if (known) chk("hold_rdata", b0.rsp_rdata, exp_rd);
      end
      b0.rsp_ready = 1'b1;
      @(negedge clk);
      b0.rsp_ready = 1'b0;
      chk("post_valid", b0.rsp_valid, 0);
      chk("post_req_ready", b0.req_ready, 1);
      chk("post_err", b0.rsp_err, 0);
      if (known) chk("post_rdata", b0.rsp_rdata, exp_rd);
      if (wr && !exp_err) ref_mem[int'(a)] = wd;
   endtask

   task automatic txn1(input logic wr, input logic [15:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
      @(negedge clk);
      chk("w0_req_ready", b1.req_ready, 1);
      b1.req_valid = 1'b1; b1.req_write = wr; b1.req_addr = a; b1.req_wdata = wd; b1.rsp_ready = 1'b0;
      @(negedge clk);
      b1.req_valid = 1'b0;
      chk("w0_valid", b1.rsp_valid, 1);
      chk("w0_rdata", b1.rsp_rdata, exp_rd);
      chk("w0_err", b1.rsp_err, 0);
      b1.rsp_ready = 1'b1;
      @(negedge clk);
      b1.rsp_ready = 1'b0;
      chk("w0_post_valid", b1.rsp_valid, 0);
   endtask

   initial begin
      b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = '0; b0.req_wdata = '0; b0.rsp_ready = 1'b0;
      b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = '0; b1.req_wdata = '0; b1.rsp_ready = 1'b0;
      #12;
      chk("rst_req_ready", b0.req_ready, 0);
      chk("rst_rsp_valid", b0.rsp_valid, 0);
      chk("rst_rsp_rdata", b0.rsp_rdata, 0);
      chk("rst_rsp_err", b0.rsp_err, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed: store/load, out-of-range, backpressure
      txn0(1'b1, 16'd5, 32'hDEADBEEF, 0);
      txn0(1'b0, 16'd5, 32'h0, 0);
      txn0(1'b1, 16'd1023, 32'hA5A5_1234, 0);
      txn0(1'b0, 16'd1024, 32'h0, 0);
      txn0(1'b1, 16'hFFFF, 32'h5555_AAAA, 1);
      txn0(1'b0, 16'd1023, 32'h0, 0);
      txn0(1'b0, 16'd5, 32'h0, 5);

      // Continuous requests: acceptances spaced WAITC+2 apart
      acc_q.delete();
      @(negedge clk);
      mon_en = 1'b1;
      b0.req_valid = 1'b1; b0.req_write = 1'b0; b0.rsp_ready = 1'b1;
      repeat (20) begin
         b0.req_addr = 16'($urandom_range(0, 1023));
         @(negedge clk);
      end
      mon_en = 1'b0;
      b0.req_valid = 1'b0;
      repeat (6) @(negedge clk);
      b0.rsp_ready = 1'b0;
      chk("t4_count", 32'(acc_q.size() >= 4), 1);
      for (int i = 1; i < acc_q.size(); i++) chk("t4_spacing", acc_q[i] - acc_q[i-1], WAITC + 2);

      // Reset during WAIT of a store must not commit it
      txn0(1'b1, 16'd7, 32'h0, 0);
      txn0(1'b0, 16'd5, 32'h0, 0);
      @(negedge clk);
      b0.req_valid = 1'b1; b0.req_write = 1'b1; b0.req_addr = 16'd7; b0.req_wdata = 32'h12345678;
      @(negedge clk);
      b0.req_valid = 1'b0;
      chk("t5_in_wait", b0.req_ready, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", b0.rsp_valid, 0);
      chk("t5_rst_ready", b0.req_ready, 0);
      chk("t5_rst_err", b0.rsp_err, 0);
      chk("t5_rst_rdata", b0.rsp_rdata, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      txn0(1'b0, 16'd7, 32'h0, 0);

      // Zero wait states
      txn1(1'b1, 16'd5, 32'hDEADBEEF, 32'h0);
      txn1(1'b0, 16'd5, 32'h0, 32'hDEADBEEF);

      // Randomized traffic against the model
      for (int k = 0; k < 40; k++) begin
         logic [15:0] a;
         a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1024, 65535)) : 16'($urandom_range(0, 15));
         txn0(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
